// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter sharing one external ALU between two requesters.
// Accepts one operation at a time, registers the ALU result and returns it tagged with the requester ID.
module alu_scheduler #(
  parameter int NBITS_OP  = 3,
  parameter int NBITS_CNT = 8
) (
  input  logic                 clk_2,
  input  logic                 reset_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [NBITS_OP-1:0]  req0_a,
  input  logic [NBITS_OP-1:0]  req0_b,
  input  logic [1:0]           req0_op,
  input  logic [NBITS_OP-1:0]  req1_a,
  input  logic [NBITS_OP-1:0]  req1_b,
  input  logic [1:0]           req1_op,
  output logic [NBITS_OP-1:0]  alu_a,
  output logic [NBITS_OP-1:0]  alu_b,
  output logic [1:0]           alu_op,
  input  logic [NBITS_OP:0]    alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [NBITS_OP:0]    rsp_result,
  output logic                 rsp_flag,
  output logic [NBITS_CNT-1:0] grant_cnt0,
  output logic [NBITS_CNT-1:0] grant_cnt1
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t                state;
  logic                  last_grant;
  logic                  id;
  logic [NBITS_OP-1:0]   op_a;
  logic [NBITS_OP-1:0]   op_b;
  logic [1:0]            op_code;
  logic [1:0]            pick;
  // Under contention the requester not granted last wins.
  always_comb pick = (&req_valid) ? (last_grant ? 2'b01 : 2'b10) : req_valid;
  assign req_ready = (state == IDLE) ? pick : 2'b00;
  assign alu_a  = op_a;
  assign alu_b  = op_b;
  assign alu_op = op_code;
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      case (state)
        IDLE: if (|req_ready) begin
          id         <= req_ready[1];
          last_grant <= req_ready[1];
          op_a       <= req_ready[1] ? req1_a : req0_a;
          op_b       <= req_ready[1] ? req1_b : req0_b;
          op_code    <= req_ready[1] ? req1_op : req0_op;
          if (req_ready[0] && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + NBITS_CNT'(1);
          if (req_ready[1] && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + NBITS_CNT'(1);
          state      <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flag   <= op_code[1] & alu_result[NBITS_OP];
          rsp_id     <= id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: table vectors plus corner sequences; a scoreboard queue checks every response.
module tb_alu_scheduler;
  logic       clk_2 = 0;
  logic       reset_n = 0;
  logic [1:0] req_valid = 0, req_ready;
  logic [2:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, alu_a, alu_b;
  logic [1:0] req0_op = 0, req1_op = 0, alu_op;
  logic [3:0] alu_result, rsp_result;
  logic       rsp_valid, rsp_ready = 1, rsp_id, rsp_flag;
  logic [7:0] grant_cnt0, grant_cnt1;
  int total = 0, bad = 0, cyc = 0;

  typedef struct {logic id; logic [2:0] a, b; logic [1:0] op; logic [3:0] res; logic flag;} vec_t;
  typedef struct {logic id; logic [3:0] res; logic flag;} exp_t;
  vec_t vecs[6];
  exp_t sb[$];

  alu_scheduler #(.NBITS_OP(3), .NBITS_CNT(8)) dut (
    .clk_2(clk_2), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1));

  always #5 clk_2 = ~clk_2;
  always @(posedge clk_2) cyc <= cyc + 1;

  function automatic logic [3:0] alu_f(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
    case (op)
      2'b00: alu_f = {1'b0, a & b};
      2'b01: alu_f = {1'b0, a | b};
      2'b10: alu_f = {1'b0, a} + {1'b0, b};
      default: alu_f = {1'b0, a} - {1'b0, b};
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk_2) if (reset_n) begin
    exp_t e;
    if (|(req_valid & req_ready)) begin
      e.id  = req_ready[1];
      e.res = req_ready[1] ? alu_f(req1_a, req1_b, req1_op) : alu_f(req0_a, req0_b, req0_op);
      e.flag = (req_ready[1] ? req1_op[1] : req0_op[1]) & e.res[3];
      sb.push_back(e);
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        check("sb_id", rsp_id, e.id);
        check("sb_result", rsp_result, e.res);
        check("sb_flag", rsp_flag, e.flag);
      end
    end
  end

  task automatic wait_accept(output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_2);
      if (|(req_valid & req_ready)) begin t = cyc; return; end
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_2);
      if (rsp_valid) begin t = cyc; return; end
    end
    check("rsp_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk_2); #1;
    reset_n = 0; req_valid = 0; sb.delete();
    @(posedge clk_2); #1;
    reset_n = 1;
  endtask

  initial begin
    int t, t2, tp, tr, n;
    logic [3:0] hr;
    logic hid, hf;
    vecs[0] = '{0, 3'd5, 3'd3, 2'b10, 4'b1000, 1};
    vecs[1] = '{1, 3'd2, 3'd5, 2'b11, 4'b1101, 1};
    vecs[2] = '{1, 3'd6, 3'd3, 2'b00, 4'b0010, 0};
    vecs[3] = '{0, 3'd5, 3'd2, 2'b01, 4'b0111, 0};
    vecs[4] = '{0, 3'd7, 3'd1, 2'b10, 4'b1000, 1};
    vecs[5] = '{1, 3'd3, 3'd3, 2'b11, 4'b0000, 0};
    repeat (2) @(posedge clk_2);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    check("rst_cnts", {grant_cnt0, grant_cnt1}, 0);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk_2); #1;
    reset_n = 1;

    foreach (vecs[i]) begin
      if (vecs[i].id) begin req1_a = vecs[i].a; req1_b = vecs[i].b; req1_op = vecs[i].op; end
      else begin req0_a = vecs[i].a; req0_b = vecs[i].b; req0_op = vecs[i].op; end
      req_valid = vecs[i].id ? 2'b10 : 2'b01;
      wait_accept(t);
      check("vec_ready", req_ready, vecs[i].id ? 2'b10 : 2'b01);
      @(posedge clk_2); #1;
      req_valid = 0;
      wait_rsp(t2);
      check("vec_latency", t2 - t, 2);
      check("vec_id", rsp_id, vecs[i].id);
      check("vec_result", rsp_result, vecs[i].res);
      check("vec_flag", rsp_flag, vecs[i].flag);
      @(posedge clk_2); #1;
    end
    check("vec_cnt0", grant_cnt0, 3);
    check("vec_cnt1", grant_cnt1, 3);

    do_reset();
    req0_a = 1; req0_b = 2; req0_op = 2'b10;
    req1_a = 4; req1_b = 4; req1_op = 2'b11;
    req_valid = 2'b11;
    tp = 0;
    for (int k = 0; k < 6; k++) begin
      wait_accept(t);
      check("rr_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) check("rr_interval", t - tp, 3);
      tp = t;
      @(posedge clk_2); #1;
    end
    req_valid = 0;
    wait_rsp(t2);
    @(posedge clk_2); #1;
    check("rr_cnt0", grant_cnt0, 3);
    check("rr_cnt1", grant_cnt1, 3);

    rsp_ready = 0;
    req0_a = 3; req0_b = 6; req0_op = 2'b11;
    req1_a = 5; req1_b = 2; req1_op = 2'b00;
    req_valid = 2'b01;
    wait_accept(t);
    @(posedge clk_2); #1;
    req_valid = 2'b11;
    wait_rsp(t2);
    hr = rsp_result; hid = rsp_id; hf = rsp_flag;
    check("bp_result", hr, 4'b1101);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_2);
      check("bp_valid", rsp_valid, 1);
      check("bp_stable", {rsp_id, rsp_result, rsp_flag}, {hid, hr, hf});
      check("bp_ready", req_ready, 0);
    end
    @(posedge clk_2); #1;
    rsp_ready = 1;
    @(negedge clk_2);
    tr = cyc;
    wait_accept(t);
    check("bp_accept_gap", t - tr, 1);
    check("bp_grant", req_ready, 2'b10);
    @(posedge clk_2); #1;
    req_valid = 0;
    check("exec_alu_a", alu_a, 5);
    reset_n = 0;
    sb.delete();
    #1;
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_alu", {alu_a, alu_b, alu_op}, 0);
    check("mid_cnts", {grant_cnt0, grant_cnt1}, 0);
    check("mid_req_ready", req_ready, 0);
    @(posedge clk_2); #1;
    reset_n = 1;
    req_valid = 2'b11;
    wait_accept(t);
    check("post_rst_grant", req_ready, 2'b01);
    @(posedge clk_2); #1;
    req_valid = 0;
    wait_rsp(t2);
    @(posedge clk_2); #1;

    do_reset();
    req0_a = 7; req0_b = 7; req0_op = 2'b10;
    req_valid = 2'b01;
    n = 0;
    for (int c = 0; c < 1000 && n < 260; c++) begin
      @(negedge clk_2);
      if (req_valid[0] & req_ready[0]) n++;
    end
    @(posedge clk_2); #1;
    req_valid = 0;
    wait_rsp(t2);
    @(posedge clk_2); #1;
    check("sat_accepts", n, 260);
    check("sat_cnt0", grant_cnt0, 255);
    check("sat_cnt1", grant_cnt1, 0);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
